// File: rtl/spi_cmd_sequencer_pkg.sv
// Shared constants and types for the SPI command sequencer.
package spi_seq_pkg;

  // Width of the address field carried in a command byte
  localparam int CMD_ADDR_W = 6;

  // Command opcodes (top two bits of the command byte)
  localparam logic [1:0] OP_WR   = 2'b00;
  localparam logic [1:0] OP_RD   = 2'b01;
  localparam logic [1:0] OP_STRM = 2'b10;
  localparam logic [1:0] OP_STAT = 2'b11;

  // Fixed upper nibble of every STATUS byte
  localparam logic [3:0] STATUS_MAGIC = 4'b1010;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CMD     = 3'd1,
    ST_WR      = 3'd2,
    ST_RD      = 3'd3,
    ST_STRM_HI = 3'd4,
    ST_STRM_LO = 3'd5,
    ST_STAT    = 3'd6
  } seq_state_e;

  // STATUS = {magic, 2'b00, underrun, fifo-not-empty}
  function automatic logic [7:0] status_byte(input logic underrun, input logic smp_valid);
    return {STATUS_MAGIC, 2'b00, underrun, smp_valid};
  endfunction

endpackage

// File: rtl/spi_cmd_sequencer_if.sv
// Byte / sample / config-bank bundle between the SPI peripheral side,
// the sample FIFO and the DSP configuration consumers.
interface spi_seq_if #(
  parameter int NUM_REGS = 16,
  parameter int SMP_W    = 16
) ();
  import spi_seq_pkg::*;

  logic                      rx_done;
  logic [7:0]                rx_data;
  logic [7:0]                tx_data;
  logic [SMP_W-1:0]          smp_data;
  logic                      smp_valid;
  logic                      smp_ready;
  logic [NUM_REGS*8-1:0]     cfg_regs;
  logic                      cfg_wr_stb;
  logic [CMD_ADDR_W-1:0]     cfg_wr_addr;
  logic                      busy;

  // Sequencer side
  modport slave (
    input  rx_done, rx_data, smp_data, smp_valid,
    output tx_data, smp_ready, cfg_regs, cfg_wr_stb, cfg_wr_addr, busy
  );

  // Environment side (peripheral, FIFO, config consumers)
  modport master (
    output rx_done, rx_data, smp_data, smp_valid,
    input  tx_data, smp_ready, cfg_regs, cfg_wr_stb, cfg_wr_addr, busy
  );

endinterface

// File: rtl/spi_cmd_sequencer_sync_2ff.sv
// Two-flop synchronizer with registered history for edge detection.
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q,
  output logic o_rise,
  output logic o_fall
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  // Metastability chain plus one history flop for edge detection
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
      r_prev <= RST_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_q    = r_sync;
  assign o_rise =  r_sync & ~r_prev;
  assign o_fall = ~r_sync &  r_prev;

endmodule

// File: rtl/spi_cmd_sequencer.sv
// Transaction controller behind the SPI peripheral: decodes command bytes
// into config-register writes/reads, sample streaming and status reads,
// and presents the next byte to shift out one cycle after each rx_done.
module spi_cmd_sequencer
  import spi_seq_pkg::*;
#(
  parameter int NUM_REGS = 16,
  parameter int SMP_W    = 16
) (
  input  logic      sys_clk,
  input  logic      rst_n,
  input  logic      csn_pad,
  spi_seq_if.slave  bus
);

  localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [CMD_ADDR_W:0] NREG_L = (CMD_ADDR_W+1)'(NUM_REGS);

  // Register-bank read with out-of-range addresses returning zero
  function automatic logic [7:0] reg_at(input logic [NUM_REGS*8-1:0] bank,
                                        input logic [CMD_ADDR_W-1:0] a);
    if ({1'b0, a} < NREG_L) reg_at = bank[{a[IDX_W-1:0], 3'b000} +: 8];
    else                    reg_at = 8'h00;
  endfunction

  seq_state_e              r_state;
  seq_state_e              w_state_nxt;

  logic [7:0]              r_tx;
  logic [CMD_ADDR_W-1:0]   r_ptr;
  logic [SMP_W-1:0]        r_hold;
  logic                    r_unr;
  logic [NUM_REGS*8-1:0]   r_cfg;
  logic                    r_wr_stb;
  logic [CMD_ADDR_W-1:0]   r_wr_addr;
  logic                    r_smp_rdy;

  logic                    w_csn_sync;
  logic                    w_csn_rise;
  logic                    w_csn_fall;
  logic [1:0]              w_op;
  logic [CMD_ADDR_W-1:0]   w_cmd_addr;
  logic [CMD_ADDR_W-1:0]   w_ptr_inc;
  logic [7:0]              w_status;
  logic [7:0]              w_rd_cmd;
  logic [7:0]              w_rd_next;
  logic                    w_wr_in_range;

  logic                    w_tx_load;
  logic [7:0]              w_tx_nxt;
  logic                    w_ptr_load;
  logic [CMD_ADDR_W-1:0]   w_ptr_nxt;
  logic                    w_fetch;
  logic                    w_wr_en;
  logic                    w_unr_clr;
  logic                    w_unr_set;

  sync_2ff #(.RST_VAL(1'b1)) u_csn_sync (
    .i_clk   (sys_clk),
    .i_rst_n (rst_n),
    .i_d     (csn_pad),
    .o_q     (w_csn_sync),
    .o_rise  (w_csn_rise),
    .o_fall  (w_csn_fall)
  );

  assign w_op          = bus.rx_data[7:6];
  assign w_cmd_addr    = bus.rx_data[CMD_ADDR_W-1:0];
  assign w_ptr_inc     = r_ptr + 1'b1;
  assign w_status      = status_byte(r_unr, bus.smp_valid);
  assign w_rd_cmd      = reg_at(r_cfg, w_cmd_addr);
  assign w_rd_next     = reg_at(r_cfg, w_ptr_inc);
  assign w_wr_in_range = ({1'b0, r_ptr} < NREG_L);
  assign w_unr_set     = w_fetch & ~bus.smp_valid;

  // State register
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state: frame entry on CSN fall, exit on CSN rise, byte-driven otherwise
  always_comb begin
    w_state_nxt = r_state;
    if (r_state == ST_IDLE) begin
      if (w_csn_fall) w_state_nxt = ST_CMD;
    end else if (w_csn_rise) begin
      w_state_nxt = ST_IDLE;
    end else if (bus.rx_done) begin
      case (r_state)
        ST_CMD: begin
          case (w_op)
            OP_WR:   w_state_nxt = ST_WR;
            OP_RD:   w_state_nxt = ST_RD;
            OP_STRM: w_state_nxt = ST_STRM_LO;
            default: w_state_nxt = ST_STAT;
          endcase
        end
        ST_STRM_LO: w_state_nxt = ST_STRM_HI;
        ST_STRM_HI: w_state_nxt = ST_STRM_LO;
        default:    w_state_nxt = r_state;
      endcase
    end
  end

  // Per-state actions; a byte coincident with CSN rise is still acted on
  always_comb begin
    w_tx_load  = 1'b0;
    w_tx_nxt   = r_tx;
    w_ptr_load = 1'b0;
    w_ptr_nxt  = r_ptr;
    w_fetch    = 1'b0;
    w_wr_en    = 1'b0;
    w_unr_clr  = 1'b0;
    if (r_state == ST_IDLE) begin
      w_tx_load = 1'b1;
      w_tx_nxt  = w_status;
    end else if (bus.rx_done) begin
      case (r_state)
        ST_CMD: begin
          w_ptr_load = 1'b1;
          w_ptr_nxt  = w_cmd_addr;
          case (w_op)
            OP_WR: begin
              w_tx_load = 1'b1;
              w_tx_nxt  = 8'h00;
            end
            OP_RD: begin
              w_tx_load = 1'b1;
              w_tx_nxt  = w_rd_cmd;
            end
            OP_STRM: w_fetch = 1'b1;
            default: begin
              w_unr_clr = 1'b1;
              w_tx_load = 1'b1;
              w_tx_nxt  = status_byte(1'b0, bus.smp_valid);
            end
          endcase
        end
        ST_WR: begin
          w_wr_en    = 1'b1;
          w_ptr_load = 1'b1;
          w_ptr_nxt  = w_ptr_inc;
          w_tx_load  = 1'b1;
          w_tx_nxt   = 8'h00;
        end
        ST_RD: begin
          w_ptr_load = 1'b1;
          w_ptr_nxt  = w_ptr_inc;
          w_tx_load  = 1'b1;
          w_tx_nxt   = w_rd_next;
        end
        ST_STRM_LO: begin
          w_tx_load = 1'b1;
          w_tx_nxt  = r_hold[7:0];
        end
        ST_STRM_HI: w_fetch = 1'b1;
        ST_STAT: begin
          w_tx_load = 1'b1;
          w_tx_nxt  = w_status;
        end
        default: ;
      endcase
    end
    if (w_fetch) begin
      w_tx_load = 1'b1;
      w_tx_nxt  = bus.smp_valid ? bus.smp_data[SMP_W-1 -: 8] : 8'h00;
    end
  end

  // Outgoing byte, address pointer and sample hold register
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx   <= {STATUS_MAGIC, 4'b0000};
      r_ptr  <= '0;
      r_hold <= '0;
    end else begin
      if (w_tx_load)  r_tx  <= w_tx_nxt;
      if (w_ptr_load) r_ptr <= w_ptr_nxt;
      if (w_fetch)    r_hold <= bus.smp_valid ? bus.smp_data : '0;
    end
  end

  // Sticky underrun: a set in the same cycle as a clear wins
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n)         r_unr <= 1'b0;
    else if (w_unr_set) r_unr <= 1'b1;
    else if (w_unr_clr) r_unr <= 1'b0;
  end

  // Config bank write and its one-cycle commit strobe
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cfg     <= '0;
      r_wr_stb  <= 1'b0;
      r_wr_addr <= '0;
    end else begin
      r_wr_stb <= w_wr_en & w_wr_in_range;
      if (w_wr_en && w_wr_in_range) begin
        r_cfg[{r_ptr[IDX_W-1:0], 3'b000} +: 8] <= bus.rx_data;
        r_wr_addr <= r_ptr;
      end
    end
  end

  // FIFO pop strobe, only when a sample was actually taken
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) r_smp_rdy <= 1'b0;
    else        r_smp_rdy <= w_fetch & bus.smp_valid;
  end

  // While idle the outgoing byte follows live STATUS so the first byte of a frame is current
  assign bus.tx_data     = (r_state == ST_IDLE) ? w_status : r_tx;
  assign bus.smp_ready   = r_smp_rdy;
  assign bus.cfg_regs    = r_cfg;
  assign bus.cfg_wr_stb  = r_wr_stb;
  assign bus.cfg_wr_addr = r_wr_addr;
  assign bus.busy        = ~w_csn_sync & (r_state != ST_IDLE);

endmodule

// File: doc/spi_cmd_sequencer.md
Name: spi_cmd_sequencer

Overview:
- Transaction-level controller behind spi_peripheral_v5 in the ADC/DSP design.
- Decodes received SPI bytes into register writes, register reads and ADC sample streaming.
- Drives the peripheral's D_TO_SEND byte for every byte slot of a chip-select frame.
- Owns the DSP configuration register bank and pops the sample FIFO.

Parameters:
NUM_REGS, 16, number of 8-bit config registers (2..64)
SMP_W, 16, sample width; fixed at two bytes, MSB first

Ports:
sys_clk  in  1  system clock (48 MHz)
rst_n  in  1  asynchronous active-low reset
csn_pad  in  1  raw SPI chip select, active low; synchronized internally with 2 FFs
rx_done  in  1  one-cycle pulse from peripheral, synchronous to sys_clk: byte received
rx_data  in  8  received byte, valid with rx_done
tx_data  out  8  next byte to shift out; connects to D_TO_SEND
smp_data  in  16  sample FIFO head
smp_valid  in  1  FIFO not empty
smp_ready  out  1  one-cycle pop strobe
cfg_regs  out  NUM_REGS*8  flat register bank; reg k = bits [8k+7:8k]
cfg_wr_stb  out  1  one-cycle pulse per committed register write
cfg_wr_addr  out  6  address of the committed write
busy  out  1  frame active (synchronized CSN low)

Behaviour:
- Reset: tx_data = STATUS, smp_ready = 0, cfg_regs all 0x00, cfg_wr_stb = 0, cfg_wr_addr = 0, busy = 0, underrun = 0, state = IDLE.
- STATUS byte = {4'b1010, 2'b00, underrun, smp_valid}.
- States: IDLE, CMD, WR, RD, STRM_HI, STRM_LO, STAT.
- IDLE:
  - tx_data continuously tracks STATUS.
  - On synchronized CSN falling edge, go to CMD; busy = 1.
- CMD, on rx_done, decode rx_data = {op[1:0], addr[5:0]} and latch ptr = addr:
  - op 00 (write): go to WR; tx_data = 0x00.
  - op 01 (read): go to RD; tx_data = reg[ptr].
  - op 10 (stream): fetch a sample (below); go to STRM_LO.
  - op 11 (status): clear underrun; go to STAT; tx_data = STATUS computed after the clear.
- WR, each rx_done:
  - reg[ptr] <= rx_data if ptr < NUM_REGS; else ignored and no strobe.
  - cfg_wr_stb/cfg_wr_addr pulse the cycle after rx_done.
  - ptr <= ptr + 1 with 6-bit wrap (63 -> 0).
  - tx_data = 0x00.
- RD, each rx_done: ptr <= ptr + 1 (wrap); tx_data = reg[ptr+1], or 0x00 if out of range.
- Sample fetch (on op 10 in CMD, and in STRM_HI):
  - If smp_valid: latch smp_data into the hold register, pulse smp_ready for exactly 1 cycle, tx_data = hold[15:8].
  - Else: hold = 0x0000, tx_data = 0x00, set underrun (sticky), no pop.
- STRM_LO, on rx_done: tx_data = hold[7:0]; go to STRM_HI.
- STRM_HI, on rx_done: fetch the next sample; go to STRM_LO.
- STAT, on rx_done: tx_data = STATUS (refreshed).
- Latency: tx_data updates and smp_ready asserts exactly 1 sys_clk cycle after rx_done. This is required so the peripheral loads the new byte before the next SCK edge.
- CSN deassert (synchronized rising edge) in any state:
  - Immediate return to IDLE; busy = 0.
  - A partial byte is discarded; no write, no pop.
  - A write already committed in the same cycle still completes.
- An rx_done coincident with the CSN rising edge is still processed, then the block enters IDLE.
- An rx_done while in IDLE is ignored.
- Underrun is set-priority over clear when both occur in the same cycle.
- rst_n assertion mid-frame forces all reset values asynchronously; the frame is not resumed.

Decomposition:
- Package spi_seq_pkg:
  - opcode constants OP_WR/OP_RD/OP_STRM/OP_STAT;
  - state encoding;
  - STATUS_MAGIC (4'b1010);
  - CMD_ADDR_W = 6.
- Sub-module sync_2ff (generic 2-flop synchronizer with rising/falling edge outputs) for csn_pad.

Test Plan:
- Reset then CSN low: tx_data = 0xA0 with FIFO empty, 0xA1 with smp_valid = 1; all cfg_regs = 0.
- Frame 0x03,0x11,0x22 then CSN high:
  - reg3 = 0x11, reg4 = 0x22;
  - two cfg_wr_stb pulses with addresses 3 then 4;
  - a following read frame 0x43,x,x returns tx_data 0x11 then 0x22.
- Write frame 0x0F,0xAA,0xBB with NUM_REGS = 16: reg15 = 0xAA; ptr 16 is out of range, so no strobe and no change.
- Stream 0x80 with FIFO holding 0x1234, 0xABCD:
  - tx sequence 0x12,0x34,0xAB,0xCD;
  - smp_ready pulses exactly twice, each 1 cycle after the relevant rx_done.
- Stream with FIFO empty: tx 0x00,0x00, underrun = 1 (STATUS 0xA2); frame 0xC0 clears it, next STAT byte = 0xA0.
- CSN deasserted mid-byte during STRM_LO: state IDLE within 3 cycles; no extra smp_ready; the next frame starts cleanly in CMD.
